// File: rtl/aes_pkg.sv
// Shared AES datapath constants and the state/key vector type.
package aes_pkg;

    localparam int unsigned AES_WORD_W  = 32;
    localparam int unsigned AES_NB      = 4;
    localparam int unsigned AES_NR_128  = 10;
    localparam int unsigned AES_NR_192  = 12;
    localparam int unsigned AES_NR_256  = 14;
    localparam int unsigned AES_STATE_W = AES_NB * AES_WORD_W;

    // Word 0 occupies bits [0:AES_WORD_W-1], i.e. the most significant end.
    typedef logic [0:AES_STATE_W-1] aes_state_t;

endpackage

// File: rtl/round_key_bank.sv
// Round-key storage: one slot per round index with a loaded flag, one write port
// and a combinational read port that flags illegal or unloaded slots.
module round_key_bank
    import aes_pkg::*;
#(
    parameter int unsigned WORD_W  = AES_WORD_W,
    parameter int unsigned NWORDS  = AES_NB,
    parameter int unsigned NROUNDS = AES_NR_128,
    parameter int unsigned RND_W   = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       wr_i,
    input  logic [RND_W-1:0]           wr_round_i,
    input  logic [0:NWORDS*WORD_W-1]   wr_key_i,
    input  logic                       clear_i,
    input  logic [RND_W-1:0]           rd_round_i,
    output logic [0:NWORDS*WORD_W-1]   rd_key_c_o,
    output logic                       rd_err_c_o
);

    localparam int unsigned STATE_W = NWORDS * WORD_W;
    localparam int unsigned DEPTH   = NROUNDS + 1;
    localparam logic [RND_W-1:0] MAX_RND = RND_W'(NROUNDS);

    logic [0:STATE_W-1] key_q [DEPTH];
    logic [DEPTH-1:0]   loaded_q;
    logic               wr_ok;

    assign wr_ok = wr_i && (wr_round_i <= MAX_RND);

    // Clear drops every flag first; a same-cycle write then re-marks its own slot.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                key_q[i] <= '0;
            end
            loaded_q <= '0;
        end else begin
            if (clear_i) begin
                loaded_q <= '0;
            end
            if (wr_ok) begin
                key_q[wr_round_i]    <= wr_key_i;
                loaded_q[wr_round_i] <= 1'b1;
            end
        end
    end

    // Reads see the registered contents, so a same-cycle write is not visible yet.
    always_comb begin
        rd_key_c_o = '0;
        rd_err_c_o = 1'b1;
        if (rd_round_i <= MAX_RND) begin
            if (loaded_q[rd_round_i]) begin
                rd_key_c_o = key_q[rd_round_i];
                rd_err_c_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/add_round_key_pipe.sv
// Two-stage AddRoundKey with a local round-key bank and valid/ready backpressure.
// S1 captures the beat and its key; S2 holds the XOR result as the output register.
module add_round_key_pipe
    import aes_pkg::*;
#(
    parameter int unsigned WORD_W  = AES_WORD_W,
    parameter int unsigned NWORDS  = AES_NB,
    parameter int unsigned NROUNDS = AES_NR_128,
    parameter int unsigned RND_W   = 4
) (
    input  logic                       i_clock,
    input  logic                       i_reset_n,
    input  logic                       i_key_wr,
    input  logic [RND_W-1:0]           i_key_round,
    input  logic [0:NWORDS*WORD_W-1]   i_key,
    input  logic                       i_key_clear,
    input  logic                       i_valid,
    output logic                       o_ready,
    input  logic [0:NWORDS*WORD_W-1]   i_data,
    input  logic [RND_W-1:0]           i_round,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic [0:NWORDS*WORD_W-1]   o_data,
    output logic [RND_W-1:0]           o_round,
    output logic                       o_err
);

    localparam int unsigned STATE_W = NWORDS * WORD_W;

    logic                 en1, en2;
    logic [0:STATE_W-1]   bank_key;
    logic                 bank_err;

    logic                 s1_v_q;
    logic [0:STATE_W-1]   s1_data_q;
    logic [0:STATE_W-1]   s1_key_q;
    logic [RND_W-1:0]     s1_round_q;
    logic                 s1_err_q;

    logic                 s2_v_q;
    logic [0:STATE_W-1]   s2_data_q, s2_data_d;
    logic [RND_W-1:0]     s2_round_q;
    logic                 s2_err_q;

    round_key_bank #(
        .WORD_W  (WORD_W),
        .NWORDS  (NWORDS),
        .NROUNDS (NROUNDS),
        .RND_W   (RND_W)
    ) u_bank (
        .clk_i      (i_clock),
        .rst_ni     (i_reset_n),
        .wr_i       (i_key_wr),
        .wr_round_i (i_key_round),
        .wr_key_i   (i_key),
        .clear_i    (i_key_clear),
        .rd_round_i (i_round),
        .rd_key_c_o (bank_key),
        .rd_err_c_o (bank_err)
    );

    assign en2     = !s2_v_q || i_ready;
    assign en1     = !s1_v_q || en2;
    assign o_ready = en1;

    // Error beats carry a zero key, so their data passes through unchanged.
    always_comb begin
        s2_data_d = '0;
        for (int w = 0; w < int'(NWORDS); w++) begin
            s2_data_d[w*WORD_W +: WORD_W] = s1_data_q[w*WORD_W +: WORD_W]
                                          ^ s1_key_q[w*WORD_W +: WORD_W];
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            s1_v_q     <= 1'b0;
            s1_data_q  <= '0;
            s1_key_q   <= '0;
            s1_round_q <= '0;
            s1_err_q   <= 1'b0;
        end else if (en1) begin
            s1_v_q     <= i_valid;
            s1_data_q  <= i_data;
            s1_key_q   <= bank_key;
            s1_round_q <= i_round;
            s1_err_q   <= bank_err;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            s2_v_q     <= 1'b0;
            s2_data_q  <= '0;
            s2_round_q <= '0;
            s2_err_q   <= 1'b0;
        end else if (en2) begin
            s2_v_q     <= s1_v_q;
            s2_data_q  <= s2_data_d;
            s2_round_q <= s1_round_q;
            s2_err_q   <= s1_err_q;
        end
    end

    assign o_valid = s2_v_q;
    assign o_data  = s2_data_q;
    assign o_round = s2_round_q;
    assign o_err   = s2_err_q;

endmodule

// File: tb/tb_add_round_key_pipe.sv
// Directed self-checking bench for add_round_key_pipe (AES-128 configuration).
module tb_add_round_key_pipe;
    import aes_pkg::*;

    localparam int unsigned RND_W = 4;
    localparam int unsigned NR    = AES_NR_128;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             key_wr, key_clear;
    logic [RND_W-1:0] key_round;
    aes_state_t       key;
    logic             in_valid, in_ready_o;
    aes_state_t       in_data;
    logic [RND_W-1:0] in_round;
    logic             out_valid, out_ready;
    aes_state_t       out_data;
    logic [RND_W-1:0] out_round;
    logic             out_err;

    int n_checks = 0;
    int n_pass   = 0;

    aes_state_t m_key [16];
    logic       m_loaded [16];

    always #5 clk = ~clk;

    add_round_key_pipe #(
        .WORD_W  (AES_WORD_W),
        .NWORDS  (AES_NB),
        .NROUNDS (NR),
        .RND_W   (RND_W)
    ) dut (
        .i_clock     (clk),
        .i_reset_n   (rst_n),
        .i_key_wr    (key_wr),
        .i_key_round (key_round),
        .i_key       (key),
        .i_key_clear (key_clear),
        .i_valid     (in_valid),
        .o_ready     (in_ready_o),
        .i_data      (in_data),
        .i_round     (in_round),
        .o_valid     (out_valid),
        .i_ready     (out_ready),
        .o_data      (out_data),
        .o_round     (out_round),
        .o_err       (out_err)
    );

    function automatic logic m_err(input logic [RND_W-1:0] r);
        return (r > RND_W'(NR)) || !m_loaded[r];
    endfunction

    function automatic aes_state_t m_out(input aes_state_t d, input logic [RND_W-1:0] r);
        return m_err(r) ? d : (d ^ m_key[r]);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_key[i]    = '0;
            m_loaded[i] = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_key(input logic [RND_W-1:0] r, input aes_state_t k, input logic clr);
        key_wr    = 1'b1;
        key_round = r;
        key       = k;
        key_clear = clr;
        tick();
        key_wr    = 1'b0;
        key_clear = 1'b0;
        if (clr) begin
            for (int i = 0; i < 16; i++) m_loaded[i] = 1'b0;
        end
        if (r <= RND_W'(NR)) begin
            m_key[r]    = k;
            m_loaded[r] = 1'b1;
        end
    endtask

    task automatic send_one(input aes_state_t d, input logic [RND_W-1:0] r);
        in_valid = 1'b1;
        in_data  = d;
        in_round = r;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_round !== '0 || out_err !== 1'b0)
            $display("FAIL reset_outputs: valid=%b data=%h round=%0d err=%b, want all zero",
                     out_valid, out_data, out_round, out_err);
        else n_pass++;
        rst_n = 1'b1;
        model_reset();
        tick();
        n_checks++;
        if (in_ready_o !== 1'b1) $display("FAIL reset_ready: o_ready=%b want 1", in_ready_o);
        else n_pass++;
    endtask

    // FIPS-197 App. B round 0; S1 fills on the accept edge, S2 on the next,
    // so o_valid is seen for one cycle and transfers on the second edge after accept.
    task automatic test_fips();
        aes_state_t d, exp;
        d   = 128'h3243f6a8885a308d313198a2e0370734;
        exp = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
        write_key(4'd0, 128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0);
        send_one(d, 4'd0);
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL fips_latency_early: o_valid=%b want 0", out_valid);
        else n_pass++;
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== exp || out_err !== 1'b0 || out_round !== 4'd0)
            $display("FAIL fips_result: valid=%b data=%h err=%b round=%0d want 1 %h 0 0",
                     out_valid, out_data, out_err, out_round, exp);
        else n_pass++;
        tick();
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL fips_single_beat: o_valid=%b want 0", out_valid);
        else n_pass++;
    endtask

    task automatic test_stream();
        logic [31:0] w;
        aes_state_t  d [11];
        for (int k = 0; k <= 10; k++) begin
            w = 32'h01010101 * 32'(k);
            write_key(RND_W'(k), {w, w, w, w}, 1'b0);
            d[k] = {32'hDEAD0000 + 32'(k), 32'hBEEF0000 + 32'(k), 32'h01234567, 32'h89ABCDEF ^ 32'(k)};
        end
        out_ready = 1'b1;
        for (int c = 0; c <= 12; c++) begin
            if (c < 11) begin
                in_valid = 1'b1;
                in_data  = d[c];
                in_round = RND_W'(c);
                n_checks++;
                if (in_ready_o !== 1'b1) $display("FAIL stream_ready c=%0d: o_ready=%b want 1", c, in_ready_o);
                else n_pass++;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (c >= 1 && c <= 11) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_data !== m_out(d[c-1], RND_W'(c-1)) ||
                    out_round !== RND_W'(c-1) || out_err !== 1'b0)
                    $display("FAIL stream_beat%0d: valid=%b data=%h round=%0d err=%b want data %h",
                             c-1, out_valid, out_data, out_round, out_err, m_out(d[c-1], RND_W'(c-1)));
                else n_pass++;
            end else if (c == 12) begin
                n_checks++;
                if (out_valid !== 1'b0) $display("FAIL stream_drain: o_valid=%b want 0", out_valid);
                else n_pass++;
            end
        end
    endtask

    task automatic test_back_to_back_stall();
        aes_state_t       eq_data [$];
        logic [RND_W-1:0] eq_round [$];
        aes_state_t       held, d;
        int sent = 0;
        int got  = 0;
        for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
            out_ready = !(cyc >= 2 && cyc <= 6);
            if (sent < 8) begin
                d        = {32'hCAFE0000 + 32'(sent), 32'h13579BDF, 32'h2468ACE0, 32'hF0F0F0F0 ^ 32'(sent)};
                in_valid = 1'b1;
                in_data  = d;
                in_round = RND_W'(sent);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (cyc == 2) begin
                held = out_data;
                n_checks++;
                if (in_ready_o !== 1'b0) $display("FAIL bp_ready_drop: o_ready=%b want 0 at 3rd beat", in_ready_o);
                else n_pass++;
            end
            if (cyc >= 3 && cyc <= 6) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_data !== held || in_ready_o !== 1'b0)
                    $display("FAIL bp_hold cyc=%0d: valid=%b data=%h ready=%b want 1 %h 0",
                             cyc, out_valid, out_data, in_ready_o, held);
                else n_pass++;
            end
            if (out_valid === 1'b1 && out_ready) begin
                n_checks++;
                if (eq_data.size() == 0) begin
                    $display("FAIL bp_extra_beat: data=%h with nothing outstanding", out_data);
                end else begin
                    if (out_data !== eq_data[0] || out_round !== eq_round[0] || out_err !== 1'b0)
                        $display("FAIL bp_order beat%0d: data=%h round=%0d err=%b want %h %0d 0",
                                 got, out_data, out_round, out_err, eq_data[0], eq_round[0]);
                    else n_pass++;
                    void'(eq_data.pop_front());
                    void'(eq_round.pop_front());
                end
                got++;
            end
            if (in_valid && in_ready_o === 1'b1) begin
                eq_data.push_back(m_out(in_data, in_round));
                eq_round.push_back(in_round);
                sent++;
            end
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n_checks++;
        if (got != 8 || sent != 8 || out_valid !== 1'b0)
            $display("FAIL bp_count: got=%0d sent=%0d o_valid=%b want 8 8 0", got, sent, out_valid);
        else n_pass++;
    endtask

    task automatic test_errors();
        aes_state_t d;
        aes_state_t k2;
        d  = 128'h00112233445566778899aabbccddeeff;
        k2 = 128'h0f0e0d0c0b0a09080706050403020100;
        write_key(4'd2, k2, 1'b1);
        write_key(4'd12, 128'hffffffffffffffffffffffffffffffff, 1'b0);
        send_one(d, 4'd11);
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== d || out_err !== 1'b1 || out_round !== 4'd11)
            $display("FAIL err_round11: valid=%b data=%h err=%b round=%0d want 1 %h 1 11",
                     out_valid, out_data, out_err, out_round, d);
        else n_pass++;
        send_one(d, 4'd5);
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== d || out_err !== 1'b1)
            $display("FAIL err_unloaded5: valid=%b data=%h err=%b want 1 %h 1", out_valid, out_data, out_err, d);
        else n_pass++;
        send_one(d, 4'd12);
        tick();
        n_checks++;
        if (out_data !== d || out_err !== 1'b1)
            $display("FAIL err_oob_write: data=%h err=%b want %h 1", out_data, out_err, d);
        else n_pass++;
        send_one(d, 4'd2);
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 128'h0f1f2f3f4f5f6f7f8f9fafbfcfdfefff || out_err !== 1'b0)
            $display("FAIL err_recover: valid=%b data=%h err=%b want 1 0f1f2f3f4f5f6f7f8f9fafbfcfdfefff 0",
                     out_valid, out_data, out_err);
        else n_pass++;
    endtask

    task automatic test_write_collision();
        aes_state_t ka, kb, d1, d2;
        ka = {4{32'hA5A5A5A5}};
        kb = {4{32'h0BADF00D}};
        d1 = {4{32'h12345678}};
        d2 = {4{32'h87654321}};
        write_key(4'd3, kb, 1'b0);
        key_wr    = 1'b1;
        key_round = 4'd3;
        key       = ka;
        in_valid  = 1'b1;
        in_data   = d1;
        in_round  = 4'd3;
        tick();
        key_wr  = 1'b0;
        m_key[3] = ka;
        in_data = d2;
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== {4{32'h1999A675}})
            $display("FAIL collision_old_key: valid=%b data=%h want 1 %h", out_valid, out_data, {4{32'h1999A675}});
        else n_pass++;
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== {4{32'h22C0E684}})
            $display("FAIL collision_new_key: valid=%b data=%h want 1 %h", out_valid, out_data, {4{32'h22C0E684}});
        else n_pass++;
        tick();
    endtask

    task automatic test_reset_midstream();
        aes_state_t d;
        d = 128'hfedcba9876543210fedcba9876543210;
        in_valid = 1'b1;
        in_data  = d;
        in_round = 4'd2;
        tick();
        tick();
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_err !== 1'b0)
            $display("FAIL midreset_async: valid=%b data=%h err=%b want 0 0 0", out_valid, out_data, out_err);
        else n_pass++;
        tick();
        rst_n = 1'b1;
        model_reset();
        tick();
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready_o !== 1'b1)
            $display("FAIL midreset_no_replay: valid=%b ready=%b want 0 1", out_valid, in_ready_o);
        else n_pass++;
        send_one(d, 4'd2);
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== d || out_err !== 1'b1)
            $display("FAIL midreset_unloaded: valid=%b data=%h err=%b want 1 %h 1", out_valid, out_data, out_err, d);
        else n_pass++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        key_wr    = 1'b0;
        key_clear = 1'b0;
        key_round = '0;
        key       = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_round  = '0;
        out_ready = 1'b1;
        model_reset();
        test_reset();
        test_fips();
        test_stream();
        test_back_to_back_stall();
        test_errors();
        test_write_collision();
        test_reset_midstream();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
